vxc_result_collector: RTL and testbench
=======================================

Name: vxc_result_collector

Overview:
- Receiving end of the vector-times-constant datapath. Accepts NO_OF_UNITS-wide result chunks, each with a one-cycle write strobe from the row sequencer.
- Writes each chunk to consecutive result-memory words and masks the padding lanes of the final chunk.
- Counts chunks against the programmed vector length and reports finish.
- Replaces the hand-sliced result writes with one registered write port and a completion handshake.

Parameters:
- ELEMENT_WIDTH, 32, width of one element.
- NO_OF_UNITS, 8, elements per chunk (lanes).
- ADDR_WIDTH, 10, result-memory word address width.
- BASE_ADDR, 0, address of the first chunk.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches total and arms collection.
- total  input  32  vector length in elements; sampled on start.
- chunk_in  input  ELEMENT_WIDTH*NO_OF_UNITS  result chunk; lane 0 occupies the MSBs.
- chunk_valid  input  1  one-cycle strobe qualifying chunk_in (driven by the sequencer's result_mem_we).
- mem_we  output  1  result-memory write enable.
- mem_addr  output  ADDR_WIDTH  result-memory word address.
- mem_wdata  output  ELEMENT_WIDTH*NO_OF_UNITS  result-memory write data.
- chunks_written  output  32  chunks written since the last start.
- busy  output  1  high in COLLECT.
- finish  output  1  high in DONE.
- overflow  output  1  sticky flag for an unexpected chunk.

Behaviour:
- Clock and reset: single clock, reset synchronous active-high.
- Reset values: mem_we, mem_addr, mem_wdata, chunks_written, busy, finish and overflow all 0; state IDLE.
- Reset mid-collection: reset aborts immediately; a pending write is dropped.
- State IDLE: start -> expected = (total + NO_OF_UNITS - 1) / NO_OF_UNITS, computed in 32-bit unsigned arithmetic.
  - chunks_written cleared, overflow cleared.
  - If expected == 0, go to DONE; otherwise go to COLLECT.
- State COLLECT: each chunk_valid registers one write.
  - Latency: mem_we = 1 for exactly one cycle, in the cycle after chunk_valid.
  - mem_addr = (BASE_ADDR + index) mod 2^ADDR_WIDTH, where index is the 0-based chunk number. The address wraps silently.
  - mem_wdata = chunk_in, except lanes whose global element index (index*NO_OF_UNITS + lane) >= total are forced to 0. Only the final chunk can have masked lanes.
  - chunks_written increments in the same cycle mem_we asserts.
  - chunk_valid on back-to-back cycles is legal and produces back-to-back writes with no bubble.
  - When the write of chunk expected-1 issues, transition to DONE. finish rises one cycle after that final mem_we.
- State DONE: finish held high; mem_we held 0.
  - start -> same action as in IDLE (finish drops the next cycle).
- start during COLLECT: ignored, no effect.
- chunk_valid in IDLE or DONE: chunk dropped, overflow set to 1 (sticky until start or reset).
  - Exception: when start and chunk_valid occur in the same cycle, start wins, the chunk is dropped and overflow ends 0.
- Outputs are registered; no combinational path from inputs to outputs.
- Values of total above 2^32 - NO_OF_UNITS: (total + NO_OF_UNITS - 1) is computed with wrap-around, so expected is not a valid chunk count. Such totals are outside the supported range.

Optional Feature:
- Macro: VXC_RESULT_CHECKSUM_EN.
- When defined:
  - Adds output checksum, width ELEMENT_WIDTH.
  - checksum clears on start and reset.
  - On each mem_we, checksum <= checksum XOR (XOR of all lanes of mem_wdata, after masking).
  - checksum is stable and valid while finish = 1.
- When not defined: no checksum port and no checksum logic.

Test Plan:
- Full chunks: reset, start with total=16; two chunk_valid pulses with data A then B.
  -> mem_we at cycles v1+1 and v2+1; addr 0 then 1; wdata A then B unmasked.
  -> chunks_written = 2; finish = 1 one cycle after the second write.
- Final-chunk masking: total=10, NO_OF_UNITS=8, two chunks of all-ones.
  -> chunk 1 lanes 0-1 = 0xFFFFFFFF, lanes 2-7 = 0; finish after 2 writes.
- Zero length: total=0, start.
  -> DONE the next cycle, finish = 1, no mem_we, chunks_written = 0.
- Back-to-back chunks: total=32, four consecutive chunk_valid cycles.
  -> four consecutive mem_we cycles at addr 0-3; busy high throughout COLLECT.
- Unexpected and colliding chunks:
  - chunk_valid while in DONE -> overflow = 1, no write.
  - Next start asserted together with chunk_valid -> overflow = 0, no write.
- Reset mid-collection: total=24, one chunk written, then reset.
  -> all outputs 0; a subsequent chunk_valid sets overflow and produces no write.
  - With VXC_RESULT_CHECKSUM_EN defined, checksum reads 0 after the reset.

Source files
------------

// File: rtl/vxc_result_collector.sv
// vxc_result_collector
// Receiving end of the vector-times-constant datapath. Each chunk_valid strobe
// in COLLECT becomes one registered result-memory write at consecutive word
// addresses. Lanes past the programmed vector length are zeroed, and finish is
// raised once the expected number of chunks has been written.
//
// Optional feature: define VXC_RESULT_CHECKSUM_EN to add a running XOR
// checksum output covering every word written since the last start.
//
// Handshake: there is no back-pressure. start and chunk_valid are one-cycle
// strobes that are sampled on the rising clock edge. A chunk that arrives while
// the collector is not expecting one is dropped and sets the sticky overflow
// flag. A start that arrives during COLLECT is ignored.
module vxc_result_collector #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int BASE_ADDR     = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          total,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] chunk_in,
    input  logic                                 chunk_valid,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_wdata,
    output logic [31:0]                          chunks_written,
    output logic                                 busy,
    output logic                                 finish,
    output logic                                 overflow,
    output logic [1:0]                           dbg_state
`ifdef VXC_RESULT_CHECKSUM_EN
    ,
    output logic [ELEMENT_WIDTH-1:0]             checksum
`endif
);

    localparam int CHUNK_W = ELEMENT_WIDTH * NO_OF_UNITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [31:0]            total_q;
    logic [31:0]            expected;
    logic [31:0]            total_rounded;
    logic [31:0]            expected_calc;
    logic [63:0]            chunk_base;
    logic [CHUNK_W-1:0]     masked;
    logic                   start_take;
    logic                   accept;
    logic                   stray;
    logic [ADDR_WIDTH-1:0]  base_addr;

    assign base_addr = ADDR_WIDTH'(BASE_ADDR);

    // Chunk count for a new run, computed as a ceiling divide of the element count
    always_comb begin
        total_rounded = total + 32'(NO_OF_UNITS - 1);
        expected_calc = total_rounded / 32'(NO_OF_UNITS);
    end

    // Classify this cycle's strobes: a start that is taken, a chunk that is accepted, or a stray chunk
    always_comb begin
        start_take = start && (state != COLLECT);
        accept     = chunk_valid && (state == COLLECT) && (chunks_written < expected);
        stray      = chunk_valid && !accept && !start_take;
    end

    // Zero every lane whose global element index lies past the programmed total (lane 0 is the MSBs)
    always_comb begin
        masked     = chunk_in;
        chunk_base = 64'(chunks_written) * 64'(NO_OF_UNITS);
        for (int lane = 0; lane < NO_OF_UNITS; lane++) begin
            if ((chunk_base + 64'(lane)) >= {32'd0, total_q}) begin
                masked[(NO_OF_UNITS-1-lane)*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: leave COLLECT only after the final write has been issued
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = (expected_calc == 32'd0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (mem_we && (chunks_written == expected)) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs, decoded from the state register only
    always_comb begin
        busy      = (state == COLLECT);
        finish    = (state == DONE);
        dbg_state = state;
    end

    // Write port, chunk counter and run parameters; a start clears the run, an accepted chunk issues one write
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            chunks_written <= '0;
            overflow       <= 1'b0;
            total_q        <= '0;
            expected       <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_take) begin
                total_q        <= total;
                expected       <= expected_calc;
                chunks_written <= '0;
                overflow       <= 1'b0;
            end else begin
                if (accept) begin
                    mem_we         <= 1'b1;
                    mem_addr       <= base_addr + chunks_written[ADDR_WIDTH-1:0];
                    mem_wdata      <= masked;
                    chunks_written <= chunks_written + 32'd1;
                end
                if (stray) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef VXC_RESULT_CHECKSUM_EN
    logic [ELEMENT_WIDTH-1:0] word_xor;

    // XOR-fold the lanes of the word currently being written
    always_comb begin
        word_xor = '0;
        for (int lane = 0; lane < NO_OF_UNITS; lane++) begin
            word_xor = word_xor ^ mem_wdata[lane*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
    end

    // Running checksum: fold in each written word; cleared when a new run starts
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (start_take) begin
            checksum <= '0;
        end else if (mem_we) begin
            checksum <= checksum ^ word_xor;
        end
    end
`endif

endmodule

// File: tb/tb_vxc_result_collector.sv
// Testbench for vxc_result_collector: table-driven runs followed by
// hand-written overflow, start/chunk collision and mid-run reset sequences.
module tb_vxc_result_collector;

    localparam int EW = 32;
    localparam int NU = 8;
    localparam int AW = 10;
    localparam int CW = EW * NU;

    localparam logic [CW-1:0] DA = {32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008,
                                    32'h00000010, 32'h00000020, 32'h00000040, 32'h00000080};
    localparam logic [CW-1:0] DB = {32'h00000100, 32'h00000200, 32'h00000400, 32'h00000800,
                                    32'h00001000, 32'h00002000, 32'h00004000, 32'h00008000};
    localparam logic [CW-1:0] ONES  = {CW{1'b1}};
    localparam logic [CW-1:0] MASK2 = {64'hFFFFFFFF_FFFFFFFF, 192'h0};
    localparam logic [CW-1:0] C0 = {8{32'hC0C0C0C0}};
    localparam logic [CW-1:0] C1 = {8{32'h3C3C3C3C}};
    localparam logic [CW-1:0] C2 = {8{32'h12345678}};
    localparam logic [CW-1:0] C3 = {8{32'h9ABCDEF0}};
    localparam logic [CW-1:0] D0 = {8{32'hD0D0D0D0}};
    localparam logic [CW-1:0] D1 = {8{32'hD1D1D1D1}};
    localparam logic [CW-1:0] D2 = {32'hAAAA5555, {7{32'hFFFF0000}}};
    localparam logic [CW-1:0] D2E = {32'hAAAA5555, 224'h0};
    localparam logic [CW-1:0] Z = '0;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   total;
    logic [CW-1:0] chunk_in;
    logic          chunk_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_wdata;
    logic [31:0]   chunks_written;
    logic          busy;
    logic          finish;
    logic          overflow;
    logic [1:0]    dbg_state;
`ifdef VXC_RESULT_CHECKSUM_EN
    logic [EW-1:0] checksum;
`endif

    vxc_result_collector #(
        .ELEMENT_WIDTH(EW),
        .NO_OF_UNITS(NU),
        .ADDR_WIDTH(AW),
        .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .total(total),
        .chunk_in(chunk_in),
        .chunk_valid(chunk_valid),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .chunks_written(chunks_written),
        .busy(busy),
        .finish(finish),
        .overflow(overflow),
        .dbg_state(dbg_state)
`ifdef VXC_RESULT_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0]         total;
        logic [2:0]          n;
        logic                gap;
        logic [3:0][CW-1:0]  data;
        logic [3:0][CW-1:0]  exp;
        logic [31:0]         exp_cw;
        logic [31:0]         exp_sum;
    } vec_t;

    vec_t vecs [5];

    logic [CW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [CW-1:0] obs_q[$];
    logic [AW-1:0] obs_addr_q[$];

    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(input logic [31:0] t, input int n, input logic gap,
                                input logic [CW-1:0] d0, input logic [CW-1:0] d1,
                                input logic [CW-1:0] d2, input logic [CW-1:0] d3,
                                input logic [CW-1:0] e0, input logic [CW-1:0] e1,
                                input logic [CW-1:0] e2, input logic [CW-1:0] e3,
                                input logic [31:0] cw, input logic [31:0] sum);
        vec_t v;
        v.total   = t;
        v.n       = 3'(n);
        v.gap     = gap;
        v.data    = {d3, d2, d1, d0};
        v.exp     = {e3, e2, e1, e0};
        v.exp_cw  = cw;
        v.exp_sum = sum;
        return v;
    endfunction

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Advance to the next falling edge and record any write seen there
    task automatic step();
        @(negedge clk);
        if (mem_we === 1'b1) begin
            obs_q.push_back(mem_wdata);
            obs_addr_q.push_back(mem_addr);
        end
    endtask

    task automatic compare_writes(input string name);
        logic [CW-1:0] d;
        logic [AW-1:0] a;
        check($sformatf("%s write count", name), CW'(obs_q.size()), CW'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            d = obs_q.pop_front();
            a = obs_addr_q.pop_front();
            check($sformatf("%s addr", name), CW'(a), CW'(exp_addr_q.pop_front()));
            check($sformatf("%s wdata", name), d, exp_q.pop_front());
        end
        exp_q.delete();
        exp_addr_q.delete();
        obs_q.delete();
        obs_addr_q.delete();
    endtask

    task automatic run_vector(input vec_t v, input string name);
        int n;
        n = int'(v.n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v.exp[i]);
            exp_addr_q.push_back(AW'(i));
        end
        start = 1'b1;
        total = v.total;
        step();
        start = 1'b0;
        if (n == 0) begin
            check({name, " finish after start"}, CW'(finish), CW'(1));
        end else begin
            check({name, " busy after start"}, CW'(busy), CW'(1));
            check({name, " finish after start"}, CW'(finish), CW'(0));
        end
        for (int i = 0; i < n; i++) begin
            chunk_valid = 1'b1;
            chunk_in    = v.data[i];
            step();
            chunk_valid = 1'b0;
            if (v.gap && i != n - 1) step();
        end
        if (n > 0) begin
            check({name, " busy at last write"}, CW'(busy), CW'(1));
            check({name, " finish at last write"}, CW'(finish), CW'(0));
            step();
        end
        check({name, " finish"}, CW'(finish), CW'(1));
        check({name, " busy done"}, CW'(busy), CW'(0));
        check({name, " chunks_written"}, CW'(chunks_written), CW'(v.exp_cw));
        check({name, " mem_we done"}, CW'(mem_we), CW'(0));
`ifdef VXC_RESULT_CHECKSUM_EN
        check({name, " checksum"}, CW'(checksum), CW'(v.exp_sum));
`endif
        compare_writes(name);
    endtask

    initial begin
        vecs[0] = mk(32'd16, 2, 1'b1, DA, DB, Z, Z, DA, DB, Z, Z, 32'd2, 32'h0000FFFF);
        vecs[1] = mk(32'd10, 2, 1'b0, ONES, ONES, Z, Z, ONES, MASK2, Z, Z, 32'd2, 32'h0);
        vecs[2] = mk(32'd0, 0, 1'b0, Z, Z, Z, Z, Z, Z, Z, Z, 32'd0, 32'h0);
        vecs[3] = mk(32'd17, 3, 1'b1, D0, D1, D2, Z, D0, D1, D2E, Z, 32'd3, 32'hAAAA5555);
        vecs[4] = mk(32'd32, 4, 1'b0, C0, C1, C2, C3, C0, C1, C2, C3, 32'd4, 32'h0);

        reset       = 1'b1;
        start       = 1'b0;
        total       = '0;
        chunk_in    = '0;
        chunk_valid = 1'b0;
        step();
        step();
        check("reset mem_we", CW'(mem_we), CW'(0));
        check("reset mem_addr", CW'(mem_addr), CW'(0));
        check("reset mem_wdata", mem_wdata, Z);
        check("reset chunks_written", CW'(chunks_written), CW'(0));
        check("reset busy", CW'(busy), CW'(0));
        check("reset finish", CW'(finish), CW'(0));
        check("reset overflow", CW'(overflow), CW'(0));
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run_vector(vecs[i], $sformatf("vec%0d", i));
        end

        // Stray chunk while in DONE
        chunk_valid = 1'b1;
        chunk_in    = ONES;
        step();
        chunk_valid = 1'b0;
        check("stray overflow", CW'(overflow), CW'(1));
        check("stray mem_we", CW'(mem_we), CW'(0));
        check("stray finish held", CW'(finish), CW'(1));

        // Start together with a chunk: start wins, chunk dropped, overflow cleared
        start       = 1'b1;
        total       = 32'd8;
        chunk_valid = 1'b1;
        chunk_in    = ONES;
        step();
        start       = 1'b0;
        chunk_valid = 1'b0;
        check("collide overflow", CW'(overflow), CW'(0));
        check("collide busy", CW'(busy), CW'(1));
        check("collide finish", CW'(finish), CW'(0));
        check("collide mem_we", CW'(mem_we), CW'(0));
        exp_q.push_back(DB);
        exp_addr_q.push_back(AW'(0));
        chunk_valid = 1'b1;
        chunk_in    = DB;
        step();
        chunk_valid = 1'b0;
        check("collide chunks_written", CW'(chunks_written), CW'(1));
        step();
        check("collide finish after write", CW'(finish), CW'(1));
        compare_writes("collide");

        // Reset mid-collection, with a chunk pending in the reset cycle
        start = 1'b1;
        total = 32'd24;
        step();
        start = 1'b0;
        exp_q.push_back(DA);
        exp_addr_q.push_back(AW'(0));
        chunk_valid = 1'b1;
        chunk_in    = DA;
        step();
        check("midreset first write count", CW'(chunks_written), CW'(1));
        chunk_in = DB;
        reset    = 1'b1;
        step();
        chunk_valid = 1'b0;
        check("midreset mem_we", CW'(mem_we), CW'(0));
        check("midreset mem_addr", CW'(mem_addr), CW'(0));
        check("midreset mem_wdata", mem_wdata, Z);
        check("midreset chunks_written", CW'(chunks_written), CW'(0));
        check("midreset busy", CW'(busy), CW'(0));
        check("midreset finish", CW'(finish), CW'(0));
        check("midreset overflow", CW'(overflow), CW'(0));
`ifdef VXC_RESULT_CHECKSUM_EN
        check("midreset checksum", CW'(checksum), CW'(0));
`endif
        reset = 1'b0;
        step();
        chunk_valid = 1'b1;
        chunk_in    = ONES;
        step();
        chunk_valid = 1'b0;
        check("post-reset overflow", CW'(overflow), CW'(1));
        check("post-reset mem_we", CW'(mem_we), CW'(0));
        step();
        check("post-reset busy", CW'(busy), CW'(0));
        compare_writes("midreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
